sort_controller: RTL and testbench

//  Sequencer for the ASCII character sorter: accepts one packed word of N characters over a valid/ready

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_if.sv | 30 +++
 rtl/sort_cmp_swap.sv | 19 +
 rtl/sort_controller.sv | 106 ++++++++++
 tb/tb_sort_controller.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and sizing helpers for the character sorter
package sort_pkg;

  localparam int DEF_N_CHARS = 4;
  localparam int DEF_CHAR_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width needed to hold the worst-case swap count N*(N-1)/2
  function automatic int swc_w(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/sort_if.sv
// rtl/sort_if.sv - word-in / sorted-word-out handshake bundle for the sorter
interface sort_if
  import sort_pkg::*;
#(
  parameter int N_CHARS = DEF_N_CHARS,
  parameter int CHAR_W  = DEF_CHAR_W
) ();

  localparam int SWC_W = swc_w(N_CHARS);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_CHARS*CHAR_W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_CHARS*CHAR_W-1:0] out_data;
  logic                      busy;
  logic [SWC_W-1:0]          swap_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, swap_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, swap_count
  );

endinterface

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - single unsigned compare/swap step shared by every sort cycle
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W
) (
  input  logic [CHAR_W-1:0] a,
  input  logic [CHAR_W-1:0] b,
  output logic              gt,
  output logic [CHAR_W-1:0] lo,
  output logic [CHAR_W-1:0] hi
);

  // Strict compare: equal characters are never swapped, which keeps the sort stable
  assign gt = (a > b);
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule

// File: rtl/sort_controller.sv
// rtl/sort_controller.sv - insertion-sort sequencer: accept word, sort one compare per cycle, return result
module sort_controller
  import sort_pkg::*;
#(
  parameter int N_CHARS = DEF_N_CHARS,
  parameter int CHAR_W  = DEF_CHAR_W
) (
  input  logic   clk,
  input  logic   rst,
  sort_if.slave  bus
);

  localparam int IW    = (N_CHARS > 2) ? $clog2(N_CHARS) : 1;
  localparam int SWC_W = swc_w(N_CHARS);

  typedef logic [IW-1:0] idx_t;
  localparam idx_t ONE  = idx_t'(1);
  localparam idx_t LAST = idx_t'(N_CHARS - 1);

  state_t            state, state_nxt;
  logic [CHAR_W-1:0] lanes [N_CHARS];
  idx_t              i, j;
  logic [SWC_W-1:0]  swc;
  logic              out_valid_q;

  logic [CHAR_W-1:0] cmp_a, cmp_b, lo, hi;
  logic              gt, pass_end, accept, deliver;

  assign cmp_a    = lanes[j - ONE];
  assign cmp_b    = lanes[j];
  assign pass_end = !gt || (j == ONE);
  assign accept   = (state == S_IDLE) && bus.in_valid;
  assign deliver  = (state == S_DONE) && out_valid_q && bus.out_ready;

  sort_cmp_swap #(.CHAR_W(CHAR_W)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lo (lo),
    .hi (hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SORT;
      S_SORT:  if (pass_end && (i == LAST)) state_nxt = S_DONE;
      S_DONE:  if (deliver) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CHARS; k++) lanes[k] <= '0;
      i           <= ONE;
      j           <= ONE;
      swc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Registered valid: the result is presented one cycle after the last compare lands
      out_valid_q <= (state == S_DONE) && !deliver;
      if (accept) begin
        for (int k = 0; k < N_CHARS; k++)
          lanes[k] <= bus.in_data[(N_CHARS-1-k)*CHAR_W +: CHAR_W];
        i   <= ONE;
        j   <= ONE;
        swc <= '0;
      end else if (state == S_SORT) begin
        if (gt) begin
          lanes[j - ONE] <= lo;
          lanes[j]       <= hi;
          swc            <= swc + SWC_W'(1);
        end
        if (pass_end) begin
          if (i != LAST) begin
            i <= i + ONE;
            j <= i + ONE;
          end
        end else begin
          j <= j - ONE;
        end
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < N_CHARS; k++)
      bus.out_data[(N_CHARS-1-k)*CHAR_W +: CHAR_W] = lanes[k];
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.busy       = (state == S_SORT);
  assign bus.out_valid  = out_valid_q;
  assign bus.swap_count = swc;

endmodule

// File: tb/tb_sort_controller.sv
// tb/tb_sort_controller.sv - directed and randomized self-checking bench for sort_controller
module tb_sort_controller;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_if bus ();

  sort_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_word(input logic [31:0] d, input logic [31:0] exp_d,
                          input int exp_swc, input int exp_lat, input string tag);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_in_ready_sort"}, bus.in_ready, 0);
    wait_valid(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, bus.out_data, exp_d);
    check({tag, "_swaps"}, bus.swap_count, exp_swc);
    tick();
    check({tag, "_out_valid_after"}, bus.out_valid, 0);
    check({tag, "_in_ready_after"}, bus.in_ready, 1);
    check({tag, "_swaps_held"}, bus.swap_count, exp_swc);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic        got;
    logic [31:0] d, exp_d, od;
    logic [7:0]  ln [4];
    logic [7:0]  tmp;
    int          inv, os;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_swaps", bus.swap_count, 0);
    rst = 1'b0;

    run_word(32'h41424344, 32'h41424344, 0, 4, "abcd");
    run_word(32'h44434241, 32'h41424344, 6, 7, "dcba");
    run_word(32'h42414441, 32'h41414244, 3, 6, "bada");

    // Output stall with a second word pending
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h44434241;
    bus.out_ready = 1'b0;
    tick();
    bus.in_data = 32'h43424144;
    wait_valid(lat);
    check("stall_latency", lat, 7);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, 32'h41424344);
      check("stall_in_ready", bus.in_ready, 0);
    end
    check("stall_swaps", bus.swap_count, 6);
    bus.out_ready = 1'b1;
    tick();
    check("turn_out_valid", bus.out_valid, 0);
    check("turn_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("turn_accept_busy", bus.busy, 1);
    check("turn_accept_in_ready", bus.in_ready, 0);
    wait_valid(lat);
    check("turn_latency", lat, 5);
    check("turn_data", bus.out_data, 32'h41424344);
    check("turn_swaps", bus.swap_count, 3);
    bus.out_ready = 1'b1;
    tick();
    check("turn_done_in_ready", bus.in_ready, 1);

    // Reset in the middle of a sort
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h44434241;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_swaps", bus.swap_count, 0);
    check("mid_rst_busy", bus.busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("mid_rst_no_output", seen, 0);
    run_word(32'h43424144, 32'h41424344, 3, 5, "cbad");

    // Random words with random output stalls against a reference sort
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 4; k++)
        ln[k] = (t % 2 == 1) ? 8'($urandom_range(65, 68)) : 8'($urandom_range(0, 255));
      d   = {ln[0], ln[1], ln[2], ln[3]};
      inv = 0;
      for (int p = 0; p < 4; p++)
        for (int q = p + 1; q < 4; q++)
          if (ln[p] > ln[q]) inv++;
      for (int p = 0; p < 3; p++)
        for (int q = p + 1; q < 4; q++)
          if (ln[q] < ln[p]) begin
            tmp   = ln[p];
            ln[p] = ln[q];
            ln[q] = tmp;
          end
      exp_d = {ln[0], ln[1], ln[2], ln[3]};

      bus.in_data   = d;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      bus.in_valid = 1'b0;
      got = 1'b0;
      od  = '0;
      os  = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          od  = bus.out_data;
          os  = int'(bus.swap_count);
          got = 1'b1;
        end
        tick();
      end
      check("rand_handshake", got, 1);
      check("rand_data", od, exp_d);
      check("rand_swaps", os, inv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
